// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, IR field layout, FSM states and
// instruction classes used by the control path and the ALU.
package proc_pkg;

    localparam int IR_W     = 16;
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int RD_MSB   = 10;
    localparam int RD_LSB   = 8;
    localparam int RS_MSB   = 7;
    localparam int RS_LSB   = 5;
    localparam int RT_MSB   = 4;
    localparam int RT_LSB   = 2;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;
    localparam int SIGN_BIT = 4;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_NOP  = 5'd0;
    localparam opcode_t OP_LOAD = 5'd1;
    localparam opcode_t OP_STR  = 5'd2;
    localparam opcode_t OP_ADD  = 5'd3;
    localparam opcode_t OP_SUB  = 5'd4;
    localparam opcode_t OP_AND  = 5'd5;
    localparam opcode_t OP_ORR  = 5'd6;
    localparam opcode_t OP_LSL  = 5'd7;
    localparam opcode_t OP_LSR  = 5'd8;
    localparam opcode_t OP_ADDI = 5'd9;
    localparam opcode_t OP_ANDI = 5'd10;
    localparam opcode_t OP_ORRI = 5'd11;
    localparam opcode_t OP_CMP  = 5'd12;
    localparam opcode_t OP_B    = 5'd13;
    localparam opcode_t OP_BL   = 5'd14;
    localparam opcode_t OP_BEQ  = 5'd15;
    localparam opcode_t OP_BX   = 5'd16;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_ALU_RR,
        CL_ALU_RI,
        CL_CMP,
        CL_LOAD,
        CL_STR,
        CL_BRANCH,
        CL_BL,
        CL_BEQ,
        CL_BX,
        CL_ILLEGAL
    } op_class_t;

    function automatic opcode_t ir_opcode(input logic [IR_W-1:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] ir_rd(input logic [IR_W-1:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [2:0] ir_rs(input logic [IR_W-1:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [2:0] ir_rt(input logic [IR_W-1:0] ir);
        return ir[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [7:0] ir_imm8(input logic [IR_W-1:0] ir);
        return ir[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps the IR to an instruction class,
// ALU operand selects and the illegal-opcode flag.
import proc_pkg::*;

module ctrl_decode (
    input  logic [IR_W-1:0] ir,
    output op_class_t       op_class,
    output logic            op1_sel,
    output logic            op2_sel,
    output logic            imm_zero,
    output logic            illegal
);

    always_comb begin
        op_class = CL_ILLEGAL;
        op1_sel  = 1'b0;
        op2_sel  = 1'b0;
        imm_zero = 1'b0;
        case (ir_opcode(ir))
            OP_NOP:  op_class = CL_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LSL, OP_LSR:
                     op_class = CL_ALU_RR;
            OP_CMP:  op_class = CL_CMP;
            OP_ADDI, OP_ANDI, OP_ORRI: begin
                op_class = CL_ALU_RI;
                op2_sel  = 1'b1;
            end
            OP_LOAD: begin
                op_class = CL_LOAD;
                op2_sel  = 1'b1;
            end
            OP_STR: begin
                op_class = CL_STR;
                op2_sel  = 1'b1;
            end
            OP_B: begin
                op_class = CL_BRANCH;
                op1_sel  = 1'b1;
                op2_sel  = 1'b1;
            end
            OP_BL: begin
                op_class = CL_BL;
                op1_sel  = 1'b1;
                op2_sel  = 1'b1;
            end
            OP_BEQ: begin
                op_class = CL_BEQ;
                op1_sel  = 1'b1;
                op2_sel  = 1'b1;
            end
            // BX jumps to reg[rs] + 0, so the immediate is suppressed
            OP_BX: begin
                op_class = CL_BX;
                op2_sel  = 1'b1;
                imm_zero = 1'b1;
            end
            default: op_class = CL_ILLEGAL;
        endcase
        illegal = (op_class == CL_ILLEGAL);
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle processor control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] ->
// [WRITEBACK], owning the PC, IR and Z flag.
import proc_pkg::*;

module control_fsm (
    input  logic            clk,
    input  logic            rst,
    output logic [7:0]      imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [IR_W-1:0] imem_data,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [4:0]      alu_operation,
    output logic            alu_is_signed,
    output logic            op1_sel,
    output logic            op2_sel,
    output logic [7:0]      imm8,
    output logic [2:0]      rd_addr,
    output logic [2:0]      rs_addr,
    output logic [2:0]      rt_addr,
    output logic            reg_we,
    output logic [1:0]      wb_sel,
    input  logic [7:0]      alu_result,
    input  logic            alu_zero,
    output logic            illegal
);

    state_t          state, state_n;
    logic [7:0]      pc, pc_next, res_q;
    logic [IR_W-1:0] ir;
    logic            z;
    logic            pc_load, ir_load, z_load;

    op_class_t op_class;
    logic      dec_op1, dec_op2, dec_imm_zero, dec_illegal;

    logic       imem_req_c, dmem_req_c, dmem_we_c, reg_we_c, illegal_c;
    logic [4:0] alu_op_c;

    ctrl_decode u_decode (
        .ir       (ir),
        .op_class (op_class),
        .op1_sel  (dec_op1),
        .op2_sel  (dec_op2),
        .imm_zero (dec_imm_zero),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            z     <= 1'b0;
            res_q <= '0;
        end else begin
            state <= state_n;
            if (ir_load)
                ir <= imem_data;
            if (pc_load)
                pc <= pc_next;
            if (z_load)
                z <= alu_zero;
            if (state == S_EXECUTE)
                res_q <= alu_result;
        end
    end

    always_comb begin
        state_n       = state;
        pc_load       = 1'b0;
        pc_next       = pc + 8'd1;
        ir_load       = 1'b0;
        z_load        = 1'b0;
        imem_req_c    = 1'b0;
        dmem_req_c    = 1'b0;
        dmem_we_c     = 1'b0;
        reg_we_c      = 1'b0;
        illegal_c     = 1'b0;
        alu_op_c      = OP_NOP;
        alu_is_signed = 1'b0;
        op1_sel       = 1'b0;
        op2_sel       = 1'b0;
        wb_sel        = WB_ALU;
        case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                illegal_c = dec_illegal;
                state_n   = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_op_c      = dec_illegal ? OP_NOP : ir_opcode(ir);
                alu_is_signed = ir[SIGN_BIT];
                op1_sel       = dec_op1;
                op2_sel       = dec_op2;
                z_load        = (op_class == CL_CMP);
                case (op_class)
                    CL_LOAD, CL_STR:
                        state_n = S_MEM;
                    CL_ALU_RR, CL_ALU_RI, CL_BL:
                        state_n = S_WRITEBACK;
                    default: begin
                        state_n = S_FETCH;
                        pc_load = 1'b1;
                        if (op_class == CL_BRANCH || op_class == CL_BX ||
                            (op_class == CL_BEQ && z))
                            pc_next = alu_result;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (op_class == CL_STR);
                if (dmem_ack) begin
                    if (op_class == CL_STR) begin
                        state_n = S_FETCH;
                        pc_load = 1'b1;
                    end else begin
                        state_n = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_we_c = 1'b1;
                pc_load  = 1'b1;
                state_n  = S_FETCH;
                // BL's target was captured in EXECUTE; the link value is PC+1
                if (op_class == CL_BL) begin
                    wb_sel  = WB_LINK;
                    pc_next = res_q;
                end else if (op_class == CL_LOAD) begin
                    wb_sel  = WB_MEM;
                end
            end
            default: state_n = S_FETCH;
        endcase
    end

    assign imem_addr     = pc;
    assign imm8          = dec_imm_zero ? 8'h00 : ir_imm8(ir);
    assign rs_addr       = ir_rs(ir);
    assign rt_addr       = ir_rt(ir);
    assign rd_addr       = (op_class == CL_BL) ? LINK_REG : ir_rd(ir);

    // Strobes are forced low while rst is held so a reset cycle never requests
    assign imem_req      = imem_req_c & ~rst;
    assign dmem_req      = dmem_req_c & ~rst;
    assign dmem_we       = dmem_we_c & ~rst;
    assign reg_we        = reg_we_c & ~rst;
    assign illegal       = illegal_c & ~rst;
    assign alu_operation = rst ? OP_NOP : alu_op_c;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: table of single-instruction vectors with
// hand-computed cycle counts, strobes and PC, plus reset corner sequences.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_req, imem_ack;
    logic [15:0] imem_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [4:0]  alu_operation;
    logic        alu_is_signed, op1_sel, op2_sel;
    logic [7:0]  imm8;
    logic [2:0]  rd_addr, rs_addr, rt_addr;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [7:0]  alu_result;
    logic        alu_zero;
    logic        illegal;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] last_wb_pc;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .alu_operation (alu_operation),
        .alu_is_signed (alu_is_signed),
        .op1_sel       (op1_sel),
        .op2_sel       (op2_sel),
        .imm8          (imm8),
        .rd_addr       (rd_addr),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .illegal       (illegal)
    );

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  res;
        logic        zero;
        int          iwait;
        int          mwait;
        int          cycles;
        logic [7:0]  pc;
        int          we_cnt;
        int          ill_cnt;
        int          mreq_cnt;
        int          mwe_cnt;
        logic        chk_exec;
        logic [4:0]  aluop;
        logic        op1;
        logic        op2;
        logic [7:0]  imm;
        logic [2:0]  rd;
        logic [1:0]  wbs;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [7:0] lo);
        return {op, rd, lo};
    endfunction

    function automatic vec_t mkv(input logic [15:0] instr, input logic [7:0] res,
                                 input logic zero, input int iwait, input int mwait,
                                 input int cycles, input logic [7:0] pc, input int we_cnt,
                                 input int ill_cnt, input int mreq_cnt, input int mwe_cnt,
                                 input logic chk_exec, input logic [4:0] aluop,
                                 input logic op1, input logic op2, input logic [7:0] imm,
                                 input logic [2:0] rd, input logic [1:0] wbs);
        vec_t v;
        v.instr = instr;   v.res = res;         v.zero = zero;
        v.iwait = iwait;   v.mwait = mwait;     v.cycles = cycles;
        v.pc = pc;         v.we_cnt = we_cnt;   v.ill_cnt = ill_cnt;
        v.mreq_cnt = mreq_cnt; v.mwe_cnt = mwe_cnt; v.chk_exec = chk_exec;
        v.aluop = aluop;   v.op1 = op1;         v.op2 = op2;
        v.imm = imm;       v.rd = rd;           v.wbs = wbs;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT in FETCH.
    task automatic run_instr(input vec_t v, input string tag);
        int   ireq = 0, mreq = 0, mwe = 0, we = 0, ill = 0, cyc = 0;
        logic left = 1'b0, done = 1'b0;
        logic [4:0] x_op = '0;
        logic x_op1 = 1'b0, x_op2 = 1'b0;
        logic [7:0] x_imm = '0;
        logic [2:0] w_rd = '0;
        logic [1:0] w_sel = '0;
        imem_data  = v.instr;
        alu_result = v.res;
        alu_zero   = v.zero;
        for (int c = 0; c < 40; c++) begin
            if (left && imem_req) begin
                done = 1'b1;
                cyc  = c;
                break;
            end
            if (!imem_req) left = 1'b1;
            if (imem_req) ireq++;
            imem_ack = imem_req && (ireq > v.iwait);
            if (dmem_req) mreq++;
            if (dmem_we)  mwe++;
            dmem_ack = dmem_req && (mreq > v.mwait);
            if (illegal) ill++;
            if (reg_we) begin
                we++;
                w_rd       = rd_addr;
                w_sel      = wb_sel;
                last_wb_pc = imem_addr;
            end
            if (c == v.iwait + 2) begin
                x_op  = alu_operation;
                x_op1 = op1_sel;
                x_op2 = op2_sel;
                x_imm = imm8;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_cycles"}, cyc, v.cycles);
            chk({tag, "_pc"}, imem_addr, v.pc);
            chk({tag, "_reg_we_cnt"}, we, v.we_cnt);
            chk({tag, "_illegal_cnt"}, ill, v.ill_cnt);
            chk({tag, "_dmem_req_cnt"}, mreq, v.mreq_cnt);
            chk({tag, "_dmem_we_cnt"}, mwe, v.mwe_cnt);
            if (v.chk_exec) begin
                chk({tag, "_alu_op"}, x_op, v.aluop);
                chk({tag, "_op1_sel"}, x_op1, v.op1);
                chk({tag, "_op2_sel"}, x_op2, v.op2);
                chk({tag, "_imm8"}, x_imm, v.imm);
            end
            if (v.we_cnt > 0) begin
                chk({tag, "_rd"}, w_rd, v.rd);
                chk({tag, "_wb_sel"}, w_sel, v.wbs);
            end
        end
    endtask

    initial begin
        vec_t hv;
        rst       = 1'b1;
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;
        imem_data = '0;
        alu_result = '0;
        alu_zero  = 1'b0;

        //                 instr                               res    z  iw mw cyc pc    we il mr mw ex op     o1 o2 imm    rd wbs
        vecs[0]  = mkv(enc(5'd3,  3'd1, {3'd2, 3'd3, 2'b00}), 8'h00, 0, 0, 0, 4, 8'h01, 1, 0, 0, 0, 1, 5'd3,  0, 0, 8'h4C, 1, 0);
        vecs[1]  = mkv(enc(5'd9,  3'd2, 8'h90),               8'h00, 0, 0, 0, 4, 8'h02, 1, 0, 0, 0, 1, 5'd9,  0, 1, 8'h90, 2, 0);
        vecs[2]  = mkv(enc(5'd0,  3'd0, 8'h00),               8'h00, 0, 0, 0, 3, 8'h03, 0, 0, 0, 0, 1, 5'd0,  0, 0, 8'h00, 0, 0);
        vecs[3]  = mkv(enc(5'd12, 3'd0, {3'd1, 3'd2, 2'b00}), 8'h00, 1, 0, 0, 3, 8'h04, 0, 0, 0, 0, 1, 5'd12, 0, 0, 8'h28, 0, 0);
        vecs[4]  = mkv(enc(5'd15, 3'd0, 8'h05),               8'h09, 0, 0, 0, 3, 8'h09, 0, 0, 0, 0, 1, 5'd15, 1, 1, 8'h05, 0, 0);
        vecs[5]  = mkv(enc(5'd12, 3'd0, {3'd1, 3'd2, 2'b00}), 8'h00, 0, 0, 0, 3, 8'h0A, 0, 0, 0, 0, 1, 5'd12, 0, 0, 8'h28, 0, 0);
        vecs[6]  = mkv(enc(5'd15, 3'd0, 8'h05),               8'h0F, 1, 0, 0, 3, 8'h0B, 0, 0, 0, 0, 1, 5'd15, 1, 1, 8'h05, 0, 0);
        vecs[7]  = mkv(enc(5'd20, 3'd0, 8'h00),               8'h00, 0, 0, 0, 3, 8'h0C, 0, 1, 0, 0, 0, 5'd0,  0, 0, 8'h00, 0, 0);
        vecs[8]  = mkv(enc(5'd2,  3'd3, 8'h10),               8'h55, 0, 0, 0, 4, 8'h0D, 0, 0, 1, 1, 1, 5'd2,  0, 1, 8'h10, 0, 0);
        vecs[9]  = mkv(enc(5'd1,  3'd4, 8'h20),               8'h60, 0, 0, 3, 8, 8'h0E, 1, 0, 4, 0, 1, 5'd1,  0, 1, 8'h20, 4, 1);
        vecs[10] = mkv(enc(5'd3,  3'd6, {3'd0, 3'd1, 2'b00}), 8'h00, 0, 2, 0, 6, 8'h0F, 1, 0, 0, 0, 1, 5'd3,  0, 0, 8'h04, 6, 0);
        vecs[11] = mkv(enc(5'd13, 3'd0, 8'hF0),               8'hFF, 0, 0, 0, 3, 8'hFF, 0, 0, 0, 0, 1, 5'd13, 1, 1, 8'hF0, 0, 0);
        vecs[12] = mkv(enc(5'd0,  3'd0, 8'h00),               8'h00, 0, 0, 0, 3, 8'h00, 0, 0, 0, 0, 1, 5'd0,  0, 0, 8'h00, 0, 0);
        vecs[13] = mkv(enc(5'd13, 3'd0, 8'hFF),               8'hFF, 0, 0, 0, 3, 8'hFF, 0, 0, 0, 0, 1, 5'd13, 1, 1, 8'hFF, 0, 0);
        vecs[14] = mkv(enc(5'd14, 3'd0, 8'h41),               8'h40, 0, 0, 0, 4, 8'h40, 1, 0, 0, 0, 1, 5'd14, 1, 1, 8'h41, 7, 2);
        vecs[15] = mkv(enc(5'd16, 3'd0, {3'd5, 5'b01011}),    8'h33, 0, 0, 0, 3, 8'h33, 0, 0, 0, 0, 1, 5'd16, 0, 1, 8'h00, 0, 0);
        vecs[16] = mkv(enc(5'd8,  3'd5, {3'd6, 3'd7, 2'b00}), 8'h00, 0, 0, 0, 4, 8'h34, 1, 0, 0, 0, 1, 5'd8,  0, 0, 8'hDC, 5, 0);

        // Reset state: strobes low while held, FETCH at PC 0 once released
        repeat (3) @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_alu_op", alu_operation, 0);
        chk("rst_pc", imem_addr, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_imem_req", imem_req, 1);

        for (int i = 0; i < 17; i++) begin
            run_instr(vecs[i], $sformatf("v%0d", i));
            if (i == 14)
                chk("bl_link_wrap", 8'(last_wb_pc + 8'd1), 8'h00);
        end

        // Set Z so the post-reset BEQ proves reset clears it
        hv = mkv(enc(5'd12, 3'd0, 8'h00), 8'h00, 1, 0, 0, 3, 8'h35, 0, 0, 0, 0, 0, 5'd0, 0, 0, 8'h00, 0, 0);
        run_instr(hv, "cmp_z1");

        // Reset during MEM of a STR whose ack never arrives
        imem_data  = enc(5'd2, 3'd1, 8'h08);
        alu_result = 8'h44;
        imem_ack   = 1'b1;
        dmem_ack   = 1'b0;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        chk("str_mem_dmem_req", dmem_req, 1);
        chk("str_mem_dmem_we", dmem_we, 1);
        rst = 1'b1;
        #1;
        chk("str_rst_dmem_req_now", dmem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("str_rst_pc", imem_addr, 8'h00);
        chk("str_rst_fetch", imem_req, 1);
        chk("str_rst_dmem_req", dmem_req, 0);
        chk("str_rst_reg_we", reg_we, 0);
        @(negedge clk);

        hv = mkv(enc(5'd15, 3'd0, 8'h76), 8'h77, 1, 0, 0, 3, 8'h01, 0, 0, 0, 0, 1, 5'd15, 1, 1, 8'h76, 0, 0);
        run_instr(hv, "beq_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
